// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Core-side request/result bundle of the multiply/divide unit.
interface muldiv_if import muldiv_pkg::*; #(parameter int WIDTH = WIDTH_DEF);

  logic             start;
  op_e              op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One MSB-first iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step import muldiv_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               bit_in,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;

  always_comb begin
    rem_sh   = {acc[WIDTH-1:0], bit_in};
    // The true difference is always below the divisor, so WIDTH bits hold it.
    rem_sub  = rem_sh[WIDTH-1:0] - operand;
    acc_next = (acc << 1) + (bit_in ? {{WIDTH{1'b0}}, operand} : {2*WIDTH{1'b0}});
    q_bit    = 1'b0;
    if (is_div) begin
      if (rem_sh >= {1'b0, operand}) begin
        q_bit    = 1'b1;
        acc_next = {{WIDTH{1'b0}}, rem_sub};
      end else begin
        acc_next = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle.
// Define MDU_SIGNED_EN to enable signed MULT/DIV; otherwise op[0] is ignored.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   rs_raw;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               zero_div;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               dbz_r;

  logic [2*WIDTH-1:0] acc_next;
  logic               q_bit;
  logic               is_signed;
  logic               is_div_op;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;
  logic               accept;
  logic               last;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .bit_in   (shreg[WIDTH-1]),
    .is_div   (is_div),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  always_comb begin
`ifdef MDU_SIGNED_EN
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
`else
    is_signed = 1'b0;
`endif
    is_div_op = (bus.op == OP_DIVU) || (bus.op == OP_DIV);
    rs_neg    = is_signed & bus.rs_data[WIDTH-1];
    rt_neg    = is_signed & bus.rt_data[WIDTH-1];
    rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
    rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;
    accept    = bus.start && (state != S_RUN);
    last      = (state == S_RUN) && (cnt == CNT_W'(WIDTH - 1));
  end

  // Final result is formed from the last iteration's outputs so HI/LO load on that same edge.
  always_comb begin
    quot   = {shreg[WIDTH-2:0], q_bit};
    rem    = acc_next[WIDTH-1:0];
    hi_res = '0;
    lo_res = '0;
    if (!is_div) begin
      {hi_res, lo_res} = neg_res ? -acc_next : acc_next;
    end else if (zero_div) begin
      hi_res = rs_raw;
      lo_res = '1;
    end else begin
      lo_res = neg_res ? -quot : quot;
      hi_res = neg_rem ? -rem : rem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      shreg    <= '0;
      rs_raw   <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      zero_div <= 1'b0;
      hi_r     <= '0;
      lo_r     <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      dbz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state    <= S_RUN;
            busy_r   <= 1'b1;
            cnt      <= '0;
            acc      <= '0;
            operand  <= rt_mag;
            shreg    <= rs_mag;
            rs_raw   <= bus.rs_data;
            is_div   <= is_div_op;
            neg_res  <= rs_neg ^ rt_neg;
            neg_rem  <= rs_neg;
            zero_div <= is_div_op && (bus.rt_data == '0);
          end else begin
            state <= S_IDLE;
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          shreg <= {shreg[WIDTH-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (last) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            dbz_r  <= zero_div;
            hi_r   <= hi_res;
            lo_r   <= lo_res;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] got_hi, got_lo;
  logic         got_dbz;
  int           lat, busy_cyc;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour straight from the arithmetic rules, using 64-bit integers.
  function automatic void model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] mhi, output logic [W-1:0] mlo,
                                output logic mdbz);
    logic   sgn;
    longint sa, sb, q, r, p;
`ifdef MDU_SIGNED_EN
    sgn = (op == OP_MULT) || (op == OP_DIV);
`else
    sgn = 1'b0;
`endif
    sa   = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb   = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    mdbz = 1'b0;
    if (op == OP_DIVU || op == OP_DIV) begin
      if (b == 0) begin
        mhi  = a;
        mlo  = '1;
        mdbz = 1'b1;
      end else begin
        q   = sa / sb;
        r   = sa % sb;
        mlo = q[31:0];
        mhi = r[31:0];
      end
    end else begin
      p          = sa * sb;
      {mhi, mlo} = p;
    end
  endfunction

  task automatic apply_stimulus(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
    apply_stimulus(op, a, b);
    lat      = -1;
    busy_cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      if (bus.busy) busy_cyc++;
      @(negedge clk);
    end
    got_hi  = bus.hi;
    got_lo  = bus.lo;
    got_dbz = bus.div_by_zero;
  endtask

  task automatic run_and_check(input string tag, input op_e op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    logic [W-1:0] ehi, elo;
    logic         edbz;
    model(op, a, b, ehi, elo, edbz);
    run_op(op, a, b);
    check_output({tag, "_lat"}, lat, 33);
    check_output({tag, "_hi"}, got_hi, ehi);
    check_output({tag, "_lo"}, got_lo, elo);
    check_output({tag, "_dbz"}, got_dbz, edbz);
  endtask

  initial begin
    int done_seen;
    op_e rop;
    logic [W-1:0] ra, rb;

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.op      = OP_MULTU;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.hi_we   = 1'b0;
    bus.lo_we   = 1'b0;
    bus.wdata   = '0;
    repeat (2) @(negedge clk);
    check_output("reset_hi", bus.hi, 0);
    check_output("reset_lo", bus.lo, 0);
    check_output("reset_busy", bus.busy, 0);
    check_output("reset_done", bus.done, 0);
    check_output("reset_dbz", bus.div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] MULTU max operands and latency");
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_output("multu_max_hi", got_hi, 32'hFFFF_FFFE);
    check_output("multu_max_lo", got_lo, 32'h0000_0001);
    check_output("multu_max_lat", lat, 33);
    check_output("multu_max_busy_cycles", busy_cyc, 32);
    @(negedge clk);
    check_output("done_is_pulse", bus.done, 0);

`ifdef MDU_SIGNED_EN
    $display("[TB] signed MULT/DIV");
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    check_output("mult_neg_hi", got_hi, 32'hFFFF_FFFF);
    check_output("mult_neg_lo", got_lo, 32'hFFFF_FFEB);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check_output("div_neg_lo", got_lo, 32'hFFFF_FFFD);
    check_output("div_neg_hi", got_hi, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_output("div_ovf_lo", got_lo, 32'h8000_0000);
    check_output("div_ovf_hi", got_hi, 32'h0000_0000);
`else
    $display("[TB] op[0] ignored in unsigned build");
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    check_output("mult_as_multu_hi", got_hi, 32'h0000_0006);
    check_output("mult_as_multu_lo", got_lo, 32'hFFFF_FFEB);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check_output("div_as_divu_lo", got_lo, 32'h7FFF_FFFC);
    check_output("div_as_divu_hi", got_hi, 32'h0000_0001);
`endif

    $display("[TB] divide by zero and plain DIVU");
    run_op(OP_DIVU, 32'd5, 32'd0);
    check_output("divz_lo", got_lo, 32'hFFFF_FFFF);
    check_output("divz_hi", got_hi, 32'h0000_0005);
    check_output("divz_flag", got_dbz, 1);
    check_output("divz_lat", lat, 33);
    @(negedge clk);
    check_output("divz_flag_clears", bus.div_by_zero, 0);
    run_op(OP_DIVU, 32'd100, 32'd7);
    check_output("divu_lo", got_lo, 32'd14);
    check_output("divu_hi", got_hi, 32'd2);
    check_output("divu_flag", got_dbz, 0);
    @(negedge clk);

    $display("[TB] start and MTHI ignored while running");
    apply_stimulus(OP_MULTU, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = OP_DIVU;
    bus.rs_data = 32'd1000;
    bus.rt_data = 32'd3;
    bus.hi_we   = 1'b1;
    bus.wdata   = 32'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    check_output("mthi_in_run_dropped", bus.hi, 32'd2);
    check_output("busy_after_ignored_start", bus.busy, 1);
    lat = -1;
    for (int k = 6; k <= 40; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check_output("ignored_start_lat", lat, 33);
    check_output("ignored_start_hi", bus.hi, 32'd0);
    check_output("ignored_start_lo", bus.lo, 32'd15);

    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check_output("mthi_idle", bus.hi, 32'h1234);
    check_output("mthi_keeps_lo", bus.lo, 32'd15);
    bus.lo_we = 1'b1;
    bus.wdata = 32'hABCD;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check_output("mtlo_idle", bus.lo, 32'hABCD);
    check_output("mtlo_keeps_hi", bus.hi, 32'h1234);

    $display("[TB] start wins over simultaneous MTHI");
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD;
    run_op(OP_MULTU, 32'd2, 32'd3);
    bus.hi_we = 1'b0;
    check_output("start_wins_hi", got_hi, 32'd0);
    check_output("start_wins_lo", got_lo, 32'd6);
    @(negedge clk);

    $display("[TB] reset in the middle of a divide");
    run_op(OP_DIVU, 32'd100, 32'd7);
    @(negedge clk);
    apply_stimulus(OP_DIVU, 32'd12345, 32'd67);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("midrst_hi", bus.hi, 0);
    check_output("midrst_lo", bus.lo, 0);
    check_output("midrst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) done_seen++;
      @(negedge clk);
    end
    check_output("midrst_no_done", done_seen, 0);
    run_and_check("after_rst", OP_DIVU, 32'd12345, 32'd67);

    $display("[TB] randomized back-to-back operations");
    for (int i = 0; i < 24; i++) begin
      rop = op_e'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'hFFFF_FFFF;
        2, 3:    rb = $urandom_range(1, 20);
        default: rb = $urandom;
      endcase
      run_and_check($sformatf("rand%0d_%s", i, rop.name()), rop, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
